// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the input_conditioner block.
// The optional hold detector is enabled with INPUT_CONDITIONER_LONG_PRESS_EN.
package input_conditioner_pkg;

   typedef enum logic {
      DB_STABLE   = 1'b0,
      DB_SETTLING = 1'b1
   } debounce_state_t;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic long_press;
   } cond_out_t;

   // Bits needed to hold the values 0..max_val, never less than one.
   function automatic int unsigned width_for(input int unsigned max_val);
      if (max_val < 32'd1) begin
         return 32'd1;
      end else begin
         return $clog2(max_val + 32'd1);
      end
   endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// One conditioned channel (debounce_ch): synchroniser, inversion, debounce FSM and
// the hold counter, which exists only with INPUT_CONDITIONER_LONG_PRESS_EN.
module input_conditioner_debounce_ch
   import input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS   = 32'd10,
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
   parameter int unsigned LONG_PRESS_TICKS = 32'd1000,
`endif
   parameter logic        INV              = 1'b0
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      in_raw,
   input  logic      tick,
   output cond_out_t ch_out
);

   localparam int unsigned      CNT_W    = width_for(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 32'd1);

   logic             sync1_r;
   logic             sync2_r;
   logic             sample_s;
   debounce_state_t  state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             level_r;
   logic             rise_r;
   logic             fall_r;
   logic             long_press_s;

   assign sample_s = sync2_r ^ INV;

   // Two-flop synchroniser for the asynchronous pin.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= in_raw;
         sync2_r <= sync1_r;
      end
   end

   // Debounce FSM: a level change must persist for DEBOUNCE_TICKS ticks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= DB_STABLE;
         cnt_r   <= CNT_ZERO;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         case (state_r)
            DB_STABLE: begin
               cnt_r <= CNT_ZERO;
               if (sample_s != level_r) begin
                  state_r <= DB_SETTLING;
               end
            end
            DB_SETTLING: begin
               // A return to the current level wins over a tick in the same cycle.
               if (sample_s == level_r) begin
                  state_r <= DB_STABLE;
                  cnt_r   <= CNT_ZERO;
               end else if (tick) begin
                  if (cnt_r == CNT_LAST) begin
                     level_r <= sample_s;
                     rise_r  <= sample_s;
                     fall_r  <= ~sample_s;
                     state_r <= DB_STABLE;
                     cnt_r   <= CNT_ZERO;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            default: begin
               state_r <= DB_STABLE;
               cnt_r   <= CNT_ZERO;
            end
         endcase
      end
   end

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
   localparam int unsigned       HOLD_W    = width_for(LONG_PRESS_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(1'b0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_TICKS - 32'd1);

   logic [HOLD_W-1:0] hold_r;
   logic              long_press_r;

   // Hold timer: saturates at the threshold so the pulse fires once per press.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_r       <= HOLD_ZERO;
         long_press_r <= 1'b0;
      end else if (!level_r) begin
         hold_r       <= HOLD_ZERO;
         long_press_r <= 1'b0;
      end else begin
         long_press_r <= tick && (hold_r == HOLD_PRE);
         if (tick && (hold_r != HOLD_MAX)) begin
            hold_r <= hold_r + HOLD_ONE;
         end
      end
   end

   assign long_press_s = long_press_r;
`else
   assign long_press_s = 1'b0;
`endif

   assign ch_out = {level_r, rise_r, fall_r, long_press_s};

endmodule

// File: rtl/input_conditioner.sv
// N-channel board input conditioner: shared tick prescaler, per-channel debounce,
// edge pulses. Long-press detection is enabled with INPUT_CONDITIONER_LONG_PRESS_EN.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int unsigned     N_CH             = 32'd12,
   parameter int unsigned     CLK_HZ           = 32'd50_000_000,
   parameter int unsigned     TICK_HZ          = 32'd1_000,
   parameter int unsigned     DEBOUNCE_TICKS   = 32'd10,
   parameter logic [N_CH-1:0] INV_MASK         = {N_CH{1'b0}},
   parameter int unsigned     LONG_PRESS_TICKS = 32'd1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] in_raw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            changed,
   output logic [N_CH-1:0] long_press
);

   localparam int unsigned      DIV      = CLK_HZ / TICK_HZ;
   localparam int unsigned      PRE_W    = width_for(DIV - 32'd1);
   localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(1'b0);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 32'd1);

   if (DIV < 32'd1) begin : g_bad_div
      $error("input_conditioner: CLK_HZ/TICK_HZ must be at least 1");
   end
   if (DEBOUNCE_TICKS < 32'd1) begin : g_bad_debounce
      $error("input_conditioner: DEBOUNCE_TICKS must be at least 1");
   end
   if (LONG_PRESS_TICKS < 32'd1) begin : g_bad_long_press
      $error("input_conditioner: LONG_PRESS_TICKS must be at least 1");
   end

   logic [PRE_W-1:0] presc_r;
   logic             tick_s;
   cond_out_t        ch_s [N_CH];

   assign tick_s = (presc_r == PRE_LAST);

   // Shared debounce tick prescaler.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r <= PRE_ZERO;
      end else if (tick_s) begin
         presc_r <= PRE_ZERO;
      end else begin
         presc_r <= presc_r + PRE_ONE;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      input_conditioner_debounce_ch #(
         .DEBOUNCE_TICKS   (DEBOUNCE_TICKS),
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
         .LONG_PRESS_TICKS (LONG_PRESS_TICKS),
`endif
         .INV              (INV_MASK[i])
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .in_raw (in_raw[i]),
         .tick   (tick_s),
         .ch_out (ch_s[i])
      );

      assign level[i]      = ch_s[i].level;
      assign rise[i]       = ch_s[i].rise;
      assign fall[i]       = ch_s[i].fall;
      assign long_press[i] = ch_s[i].long_press;
   end

   // Pulses are flop outputs, so their OR lines up with them cycle for cycle.
   assign changed = |(rise | fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (DIV=10, 3 debounce ticks,
// 5 long-press ticks, channels 0 and 1 active-low).
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   localparam int N   = 12;
   localparam int DIV = 10;
   localparam int DBT = 3;
   localparam int LPT = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] in_raw;
   logic [N-1:0] level;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic         changed;
   logic [N-1:0] long_press;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_cnt = 0;

   int rise_cnt [N];
   int fall_cnt [N];
   int lp_cnt   [N];
   int first_rise [N];
   int first_fall [N];
   int first_lp   [N];
   int chg_cnt;
   int chg_bad;

   input_conditioner #(
      .N_CH             (N),
      .CLK_HZ           (1000),
      .TICK_HZ          (100),
      .DEBOUNCE_TICKS   (DBT),
      .INV_MASK         (12'b0000_0000_0011),
      .LONG_PRESS_TICKS (LPT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_raw     (in_raw),
      .level      (level),
      .rise       (rise),
      .fall       (fall),
      .changed    (changed),
      .long_press (long_press)
   );

   always #5 clk = ~clk;

   // Edges since reset release; tick edges are the multiples of DIV.
   always @(posedge clk) begin
      if (rst) edge_cnt <= 0;
      else     edge_cnt <= edge_cnt + 1;
   end

   // Input driven after edge c: synced by c+2, settling from c+3, then DBT tick edges.
   function automatic int expected_edge(input int c);
      int n;
      int ticks;
      n = c + 3;
      ticks = 0;
      while (ticks < DBT) begin
         n++;
         if (n % DIV == 0) ticks++;
      end
      return n;
   endfunction

   function automatic int total(input int a [N]);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += a[i];
      return s;
   endfunction

   task automatic clear_mon();
      for (int i = 0; i < N; i++) begin
         rise_cnt[i] = 0;   fall_cnt[i] = 0;   lp_cnt[i] = 0;
         first_rise[i] = -1; first_fall[i] = -1; first_lp[i] = -1;
      end
      chg_cnt = 0;
      chg_bad = 0;
   endtask

   task automatic observe(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
               rise_cnt[i]++;
               if (first_rise[i] < 0) first_rise[i] = edge_cnt;
            end
            if (fall[i]) begin
               fall_cnt[i]++;
               if (first_fall[i] < 0) first_fall[i] = edge_cnt;
            end
            if (long_press[i]) begin
               lp_cnt[i]++;
               if (first_lp[i] < 0) first_lp[i] = edge_cnt;
            end
         end
         if (changed) chg_cnt++;
         if (changed !== |(rise | fall)) chg_bad++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_raw = 12'h003;
      repeat (5) @(negedge clk);
      n_checks++; if (level !== 12'h000) begin n_fail++; $display("FAIL reset_level: got %h want %h", level, 12'h000); end
      n_checks++; if (rise !== 12'h000) begin n_fail++; $display("FAIL reset_rise: got %h want %h", rise, 12'h000); end
      n_checks++; if (fall !== 12'h000) begin n_fail++; $display("FAIL reset_fall: got %h want %h", fall, 12'h000); end
      n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b want 0", changed); end
      n_checks++; if (long_press !== 12'h000) begin n_fail++; $display("FAIL reset_long_press: got %h want %h", long_press, 12'h000); end
      rst = 1'b0;
      clear_mon();
      observe(100);
      n_checks++; if (total(rise_cnt) + total(fall_cnt) + total(lp_cnt) !== 0) begin n_fail++; $display("FAIL post_reset_pulses: got %0d want 0", total(rise_cnt) + total(fall_cnt) + total(lp_cnt)); end
      n_checks++; if (chg_cnt !== 0) begin n_fail++; $display("FAIL post_reset_changed: got %0d want 0", chg_cnt); end
      n_checks++; if (level !== 12'h000) begin n_fail++; $display("FAIL post_reset_level: got %h want %h", level, 12'h000); end
   endtask

   task automatic test_clean_press();
      int c, e, lat;
      c = edge_cnt;
      e = expected_edge(c);
      in_raw[2] = 1'b1;
      clear_mon();
      observe(40);
      lat = first_rise[2] - (c + 1);
      n_checks++; if (rise_cnt[2] !== 1) begin n_fail++; $display("FAIL press_rise_count: got %0d want 1", rise_cnt[2]); end
      n_checks++; if (first_rise[2] !== e) begin n_fail++; $display("FAIL press_rise_edge: got %0d want %0d", first_rise[2], e); end
      n_checks++; if (lat < 23 || lat > 32) begin n_fail++; $display("FAIL press_latency: got %0d want 23..32", lat); end
      n_checks++; if (level[2] !== 1'b1) begin n_fail++; $display("FAIL press_level: got %b want 1", level[2]); end
      n_checks++; if (chg_cnt !== 1 || chg_bad !== 0) begin n_fail++; $display("FAIL press_changed: got %0d pulses %0d misaligned want 1 and 0", chg_cnt, chg_bad); end
      n_checks++; if (total(rise_cnt) + total(fall_cnt) !== 1) begin n_fail++; $display("FAIL press_other_pulses: got %0d want 1", total(rise_cnt) + total(fall_cnt)); end
   endtask

   task automatic test_glitch();
      in_raw[5] = 1'b1;
      clear_mon();
      observe(15);
      in_raw[5] = 1'b0;
      observe(40);
      n_checks++; if (rise_cnt[5] + fall_cnt[5] !== 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 0", rise_cnt[5] + fall_cnt[5]); end
      n_checks++; if (level[5] !== 1'b0) begin n_fail++; $display("FAIL glitch_level: got %b want 0", level[5]); end
      n_checks++; if (dut.g_ch[5].u_ch.state_r !== DB_STABLE) begin n_fail++; $display("FAIL glitch_state: got %b want %b", dut.g_ch[5].u_ch.state_r, DB_STABLE); end
      n_checks++; if (chg_cnt !== 0) begin n_fail++; $display("FAIL glitch_changed: got %0d want 0", chg_cnt); end
   endtask

   task automatic test_active_low();
      int c, e;
      c = edge_cnt;
      e = expected_edge(c);
      in_raw[0] = 1'b0;
      clear_mon();
      observe(40);
      n_checks++; if (rise_cnt[0] !== 1 || fall_cnt[0] !== 0) begin n_fail++; $display("FAIL key_press_pulses: got rise %0d fall %0d want 1 0", rise_cnt[0], fall_cnt[0]); end
      n_checks++; if (first_rise[0] !== e) begin n_fail++; $display("FAIL key_press_edge: got %0d want %0d", first_rise[0], e); end
      n_checks++; if (level[0] !== 1'b1) begin n_fail++; $display("FAIL key_press_level: got %b want 1", level[0]); end
      c = edge_cnt;
      e = expected_edge(c);
      in_raw[0] = 1'b1;
      clear_mon();
      observe(40);
      n_checks++; if (fall_cnt[0] !== 1 || rise_cnt[0] !== 0) begin n_fail++; $display("FAIL key_release_pulses: got rise %0d fall %0d want 0 1", rise_cnt[0], fall_cnt[0]); end
      n_checks++; if (first_fall[0] !== e) begin n_fail++; $display("FAIL key_release_edge: got %0d want %0d", first_fall[0], e); end
      n_checks++; if (level[0] !== 1'b0) begin n_fail++; $display("FAIL key_release_level: got %b want 0", level[0]); end
   endtask

   task automatic test_simultaneous();
      int c, e;
      c = edge_cnt;
      e = expected_edge(c);
      in_raw[3] = 1'b1;
      in_raw[7] = 1'b1;
      clear_mon();
      observe(40);
      n_checks++; if (first_rise[3] !== e || first_rise[7] !== e) begin n_fail++; $display("FAIL simul_rise_edges: got %0d %0d want %0d", first_rise[3], first_rise[7], e); end
      n_checks++; if (rise_cnt[3] !== 1 || rise_cnt[7] !== 1) begin n_fail++; $display("FAIL simul_rise_count: got %0d %0d want 1 1", rise_cnt[3], rise_cnt[7]); end
      n_checks++; if (chg_cnt !== 1 || chg_bad !== 0) begin n_fail++; $display("FAIL simul_changed: got %0d pulses %0d misaligned want 1 and 0", chg_cnt, chg_bad); end
      c = edge_cnt;
      e = expected_edge(c);
      in_raw[3] = 1'b0;
      in_raw[7] = 1'b0;
      clear_mon();
      observe(40);
      n_checks++; if (first_fall[3] !== e || first_fall[7] !== e) begin n_fail++; $display("FAIL simul_fall_edges: got %0d %0d want %0d", first_fall[3], first_fall[7], e); end
      n_checks++; if (level !== 12'h004) begin n_fail++; $display("FAIL simul_level: got %h want %h", level, 12'h004); end
   endtask

   task automatic test_reset_mid_settle();
      int e;
      in_raw[9] = 1'b1;
      clear_mon();
      observe(15);
      rst = 1'b1;
      observe(3);
      n_checks++; if (total(rise_cnt) + total(fall_cnt) !== 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d want 0", total(rise_cnt) + total(fall_cnt)); end
      n_checks++; if (level !== 12'h000) begin n_fail++; $display("FAIL midrst_level: got %h want %h", level, 12'h000); end
      rst = 1'b0;
      e = expected_edge(0);
      clear_mon();
      observe(45);
      n_checks++; if (first_rise[9] !== e || rise_cnt[9] !== 1) begin n_fail++; $display("FAIL midrst_ch9_rise: got edge %0d count %0d want %0d 1", first_rise[9], rise_cnt[9], e); end
      n_checks++; if (first_rise[2] !== e || rise_cnt[2] !== 1) begin n_fail++; $display("FAIL midrst_ch2_rise: got edge %0d count %0d want %0d 1", first_rise[2], rise_cnt[2], e); end
      n_checks++; if (total(rise_cnt) !== 2 || total(fall_cnt) !== 0) begin n_fail++; $display("FAIL midrst_totals: got rise %0d fall %0d want 2 0", total(rise_cnt), total(fall_cnt)); end
   endtask

   task automatic test_long_press();
      int c, e;
      c = edge_cnt;
      e = expected_edge(c);
      in_raw[4] = 1'b1;
      clear_mon();
      observe(300);
      n_checks++; if (first_rise[4] !== e || rise_cnt[4] !== 1) begin n_fail++; $display("FAIL hold_rise: got edge %0d count %0d want %0d 1", first_rise[4], rise_cnt[4], e); end
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
      n_checks++; if (lp_cnt[4] !== 1) begin n_fail++; $display("FAIL long_press_count: got %0d want 1", lp_cnt[4]); end
      n_checks++; if (first_lp[4] !== e + LPT * DIV) begin n_fail++; $display("FAIL long_press_edge: got %0d want %0d", first_lp[4], e + LPT * DIV); end
      n_checks++; if (total(lp_cnt) !== 1) begin n_fail++; $display("FAIL long_press_total: got %0d want 1", total(lp_cnt)); end
`else
      n_checks++; if (total(lp_cnt) !== 0) begin n_fail++; $display("FAIL long_press_disabled: got %0d want 0", total(lp_cnt)); end
`endif
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_active_low();
      test_simultaneous();
      test_reset_mid_settle();
      test_long_press();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
